// File: rtl/mmio_port_responder_if.sv
// mmio_port_responder_if: data-memory bus between load/store path and MMIO responder
interface mmio_port_responder_if;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] ReadData;
  logic        Hit;
  modport master (output Address, WriteData, MemWrite, MemRead, input ReadData, Hit);
  modport slave (input Address, WriteData, MemWrite, MemRead, output ReadData, Hit);
endinterface

// File: rtl/mmio_port_responder.sv
// mmio_port_responder: register window with output port, synchronised input, timer and irq
module mmio_port_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h1001_0040,
  parameter int          IN_WIDTH  = 8
) (
  input  logic                clk,
  input  logic                reset,
  mmio_port_responder_if.slave bus,
  input  logic [IN_WIDTH-1:0] PortIn,
  output logic [31:0]         PortOut,
  output logic                Irq
);
  logic [31:0] out_q, out_d, tload_q, tload_d, tcount_q, tcount_d, in_ext, rdata;
  logic [3:0] ctrl_q, ctrl_d;
  logic [1:0] status_q, status_d;
  logic [IN_WIDTH-1:0] s1_q, s2_q, prev_q;
  logic [4:0] off;
  logic hit, wr_out, wr_status, wr_tload, wr_ctrl, tdone_set, ten_clr;
  // address decode and combinational load data
  always_comb begin
    off = bus.Address[4:0];
    hit = (bus.Address[31:5] == BASE_ADDR[31:5]) && (bus.Address[1:0] == 2'b00) && (off <= 5'h14);
    in_ext = 32'(s2_q);
    rdata = (off == 5'h00) ? out_q :
            (off == 5'h04) ? in_ext :
            (off == 5'h08) ? {30'b0, status_q} :
            (off == 5'h0C) ? tload_q :
            (off == 5'h10) ? tcount_q : {28'b0, ctrl_q};
    bus.Hit = hit;
    bus.ReadData = (bus.MemRead && hit) ? rdata : 32'h0;
  end
  // register writes, timer step and sticky flag update
  always_comb begin
    wr_out = bus.MemWrite && hit && off == 5'h00;
    wr_status = bus.MemWrite && hit && off == 5'h08;
    wr_tload = bus.MemWrite && hit && off == 5'h0C;
    wr_ctrl = bus.MemWrite && hit && off == 5'h14;
    tcount_d = tcount_q;
    tdone_set = 1'b0;
    ten_clr = 1'b0;
    if (ctrl_q[0] && tcount_q != 32'h0) begin
      if (tcount_q == 32'h1) begin
        tdone_set = 1'b1;
        tcount_d = ctrl_q[1] ? tload_q : 32'h0;
        ten_clr = !ctrl_q[1];
      end else begin
        tcount_d = tcount_q - 32'h1;
      end
    end
    if (wr_tload) tcount_d = bus.WriteData;
    tload_d = wr_tload ? bus.WriteData : tload_q;
    out_d = wr_out ? bus.WriteData : out_q;
    ctrl_d = wr_ctrl ? bus.WriteData[3:0] : {ctrl_q[3:1], ctrl_q[0] & !ten_clr};
    status_d[0] = (s2_q != prev_q) || (status_q[0] && !(wr_status && bus.WriteData[0]));
    status_d[1] = tdone_set || (status_q[1] && !(wr_status && bus.WriteData[1]));
  end
  // state registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q <= '0;
      tload_q <= '0;
      tcount_q <= '0;
      ctrl_q <= '0;
      status_q <= '0;
      s1_q <= '0;
      s2_q <= '0;
      prev_q <= '0;
    end else begin
      out_q <= out_d;
      tload_q <= tload_d;
      tcount_q <= tcount_d;
      ctrl_q <= ctrl_d;
      status_q <= status_d;
      s1_q <= PortIn;
      s2_q <= s1_q;
      prev_q <= s2_q;
    end
  end
  assign PortOut = out_q;
  assign Irq = (status_q[0] & ctrl_q[2]) | (status_q[1] & ctrl_q[3]);
endmodule

// File: tb/tb_mmio_port_responder.sv
// tb_mmio_port_responder: directed checks of the MMIO responder register window
module tb_mmio_port_responder;
  localparam logic [31:0] BASE = 32'h1001_0040;
  logic clk = 0, reset = 0;
  logic [7:0] PortIn = 0;
  logic [31:0] PortOut;
  logic Irq;
  int n_cmp = 0, n_err = 0;
  int exp_cnt[6] = '{2, 1, 3, 2, 1, 3};
  int exp_dn[6] = '{0, 0, 2, 2, 2, 2};
  mmio_port_responder_if bus ();
  mmio_port_responder #(.BASE_ADDR(BASE), .IN_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .bus(bus), .PortIn(PortIn), .PortOut(PortOut), .Irq(Irq)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  task automatic wr(input logic [7:0] off, input logic [31:0] d);
    bus.Address = BASE + 32'(off);
    bus.WriteData = d;
    bus.MemWrite = 1;
    @(negedge clk);
    bus.MemWrite = 0;
  endtask
  task automatic rd(input string tag, input logic [7:0] off, input logic [31:0] exp);
    bus.Address = BASE + 32'(off);
    bus.MemRead = 1;
    #1;
    check(tag, bus.ReadData, exp);
    bus.MemRead = 0;
  endtask
  initial begin
    bus.Address = 0;
    bus.WriteData = 0;
    bus.MemWrite = 0;
    bus.MemRead = 0;
    step();
    step();
    reset = 1;
    rd("rst_out", 8'h00, 0);
    rd("rst_in", 8'h04, 0);
    rd("rst_status", 8'h08, 0);
    rd("rst_tload", 8'h0C, 0);
    rd("rst_tcount", 8'h10, 0);
    rd("rst_ctrl", 8'h14, 0);
    check("rst_portout", PortOut, 0);
    check("rst_irq", 32'(Irq), 0);
    bus.Address = BASE + 32'h18;
    bus.MemRead = 1;
    #1;
    check("hit_0x18", 32'(bus.Hit), 0);
    check("rd_0x18", bus.ReadData, 0);
    bus.Address = BASE + 32'h02;
    #1;
    check("hit_0x02", 32'(bus.Hit), 0);
    check("rd_0x02", bus.ReadData, 0);
    bus.Address = BASE + 32'h14;
    #1;
    check("hit_0x14", 32'(bus.Hit), 1);
    bus.MemRead = 0;
    #1;
    check("rd_noread", bus.ReadData, 0);
    wr(8'h00, 32'hDEAD_BEEF);
    check("portout", PortOut, 32'hDEAD_BEEF);
    rd("rd_out", 8'h00, 32'hDEAD_BEEF);
    wr(8'h04, 32'hFFFF_FFFF);
    rd("in_ro", 8'h04, 0);
    PortIn = 8'hA5;
    step();
    rd("in_e1", 8'h04, 0);
    step();
    rd("in_e2", 8'h04, 32'hA5);
    rd("chg_e2", 8'h08, 0);
    step();
    rd("chg_e3", 8'h08, 1);
    check("irq_noie", 32'(Irq), 0);
    wr(8'h14, 32'h4);
    check("irq_chg", 32'(Irq), 1);
    wr(8'h08, 32'h1);
    rd("chg_clr", 8'h08, 0);
    check("irq_clr", 32'(Irq), 0);
    PortIn = 8'h5A;
    step();
    step();
    step();
    rd("chg_again", 8'h08, 1);
    PortIn = 8'hC3;
    step();
    step();
    wr(8'h08, 32'h1);
    rd("chg_setwins", 8'h08, 1);
    wr(8'h08, 32'h0);
    rd("w1c_zero", 8'h08, 1);
    wr(8'h08, 32'h1);
    rd("chg_clr2", 8'h08, 0);
    wr(8'h14, 32'h0);
    wr(8'h0C, 32'd5);
    rd("tload5", 8'h0C, 5);
    rd("tcount5", 8'h10, 5);
    wr(8'h14, 32'h9);
    rd("tcnt_start", 8'h10, 5);
    for (int i = 4; i >= 1; i--) begin
      step();
      rd($sformatf("tcnt_%0d", i), 8'h10, 32'(i));
      check($sformatf("irq_pre_%0d", i), 32'(Irq), 0);
    end
    step();
    rd("tdone", 8'h08, 2);
    check("irq_tmr", 32'(Irq), 1);
    rd("tcnt_end", 8'h10, 0);
    rd("ten_clr", 8'h14, 8);
    step();
    rd("tcnt_hold", 8'h10, 0);
    wr(8'h08, 32'h2);
    rd("tdone_clr", 8'h08, 0);
    check("irq_tclr", 32'(Irq), 0);
    wr(8'h0C, 32'd3);
    wr(8'h14, 32'h3);
    for (int i = 0; i < 6; i++) begin
      step();
      rd($sformatf("auto_cnt%0d", i), 8'h10, 32'(exp_cnt[i]));
      rd($sformatf("auto_dn%0d", i), 8'h08, 32'(exp_dn[i]));
    end
    wr(8'h0C, 32'd10);
    rd("reload10", 8'h10, 10);
    step();
    rd("reload9", 8'h10, 9);
    PortIn = 8'h00;
    step();
    step();
    step();
    wr(8'h14, 32'h0);
    wr(8'h08, 32'h3);
    rd("pre_rst_st", 8'h08, 0);
    wr(8'h0C, 32'd100);
    wr(8'h14, 32'h9);
    step();
    step();
    rd("mid_count", 8'h10, 98);
    reset = 0;
    #1;
    check("arst_portout", PortOut, 0);
    rd("arst_tcount", 8'h10, 0);
    step();
    reset = 1;
    rd("post_out", 8'h00, 0);
    rd("post_tload", 8'h0C, 0);
    rd("post_ctrl", 8'h14, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      rd($sformatf("post_tcnt%0d", i), 8'h10, 0);
      rd($sformatf("post_st%0d", i), 8'h08, 0);
      check($sformatf("post_irq%0d", i), 32'(Irq), 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
